omsp_tsc_alarm: RTL and testbench
=================================

OMSP_TSC_ALARM -- requirements
Module: omsp_tsc_alarm

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h0110, meaning the peripheral base byte address, aligned to 16 bytes.
REQ-002 SHALL have parameter DEC_WD, default 4, meaning the number of address bits decoded locally (8 word registers).
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port puc_rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port per_addr, input, 14 bits: peripheral word address.
REQ-006 SHALL have port per_din, input, 16 bits: peripheral write data.
REQ-007 SHALL have port per_en, input, 1 bit: peripheral access enable, active-high.
REQ-008 SHALL have port per_we, input, 2 bits: byte write enables ([0] low byte, [1] high byte); 00 means read.
REQ-009 SHALL have port tsc, input, 64 bits: free-running time stamp counter value.
REQ-010 SHALL have port per_dout, output, 16 bits: read data, 0 when not selected.
REQ-011 SHALL have port irq, output, 1 bit: alarm interrupt request, level, active-high.

Function
REQ-012 SHALL select on per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]), with local offset {per_addr[DEC_WD-2:0],1'b0}.
REQ-013 SHALL map word registers: 0x0/0x2/0x4/0x6 CMP0..CMP3 (staged 64-bit compare, LSW first); 0x8/0xA PER0/PER1 (32-bit period); 0xC CTL; 0xE STAT.
REQ-014 SHALL apply CMPx/PERx/CTL writes per byte enable; reads return the stored value combinationally in the same cycle.
REQ-015 SHALL implement CTL bits: [0] EN, [1] PERIODIC, [2] IE; bits [15:3] read 0.
REQ-016 SHALL implement STAT bits: [0] IFG, [1] ARMED (state==ARMED), [2] MISSED; bits [15:3] read 0.
REQ-017 SHALL write STAT as write-1-to-clear on IFG and MISSED; ARMED is read-only.
REQ-018 SHALL implement a 2-state FSM: IDLE, ARMED.
REQ-019 SHALL, on a CTL write with per_din[0]=1 and per_we[0]=1, copy the staged CMP into cmp_active and enter ARMED next cycle (re-arm from ARMED reloads cmp_active).
REQ-020 SHALL, on a CTL write with EN=0 (per_we[0]=1), enter IDLE next cycle; IFG and MISSED are unchanged.
REQ-021 SHALL, in ARMED, detect hit when tsc >= cmp_active (unsigned 64-bit) and set IFG on the following edge (1-cycle latency).
REQ-022 SHALL, on a hit with PERIODIC=0 or period==0, clear EN and go IDLE in the same edge as setting IFG.
REQ-023 SHALL, on a hit with PERIODIC=1 and period!=0, stay ARMED with cmp_active <= cmp_active + zero-extended period, modulo 2^64 (wraps).
REQ-024 SHALL set MISSED when a hit occurs while IFG is already 1.
REQ-025 SHALL, when a hit and a W1C clear of IFG occur in the same cycle, leave IFG=1 and leave MISSED unchanged (hit wins).
REQ-026 SHALL, when an arming CTL write and a hit occur in the same cycle, set IFG for the hit and load the new staged compare (arm wins for cmp_active and state).
REQ-027 SHALL drive irq = IFG & IE, registered-state derived with no combinational path from per_* inputs.

Reset
REQ-028 SHALL, while puc_rst=1 at a rising mclk, clear CMP, PER, CTL, cmp_active, IFG, and MISSED to 0 and set the state to IDLE; irq and per_dout read 0 afterwards.
REQ-029 SHALL let reset asserted mid-ARMED abandon the alarm with no IFG set, even if a hit coincides with it.

Verification
REQ-030 SHALL test one-shot: CMP=0x100, tsc ramps from 0xF0, CTL=0x5 -> IFG=1 and irq=1 on the edge after tsc=0x100; STAT reads 0x1; state IDLE; CTL reads 0x4.
REQ-031 SHALL test periodic: CMP=0x100, PER=0x20, CTL=0x7, IFG cleared each hit -> hits at tsc 0x100, 0x120, 0x140; STAT.ARMED stays 1.
REQ-032 SHALL test missed: periodic as above, no IFG clear -> second hit sets MISSED; STAT reads 0x7; W1C 0x5 -> STAT reads 0x2.
REQ-033 SHALL test wrap: CMP=0xFFFF_FFFF_FFFF_FFF0, PER=0x20, periodic -> cmp_active wraps to 0x10; a subsequent tsc=0x10 hits.
REQ-034 SHALL test collision: W1C IFG in the same cycle as a hit -> IFG stays 1 and MISSED stays 0; a byte write with per_we=01 to CMP1 changes only bits [7:0].
REQ-035 SHALL test reset: puc_rst pulsed while ARMED at a hit cycle -> all registers read 0 and irq=0; an unselected address reads per_dout=0.

Source files
------------

// File: rtl/omsp_tsc_alarm_if.sv
// rtl/omsp_tsc_alarm_if.sv - openMSP430-style peripheral bus bundle for the TSC alarm
interface omsp_tsc_alarm_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/omsp_tsc_alarm.sv
// rtl/omsp_tsc_alarm.sv - 64-bit time stamp counter alarm with one-shot/periodic modes
module omsp_tsc_alarm #(
    parameter logic [14:0] BASE_ADDR = 15'h0110,
    parameter int          DEC_WD    = 4
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    omsp_tsc_alarm_if.slave       bus,
    input  logic [63:0]           tsc,
    output logic                  irq
);
    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

    localparam logic [DEC_WD-1:0] OFF_CMP0 = DEC_WD'('h0);
    localparam logic [DEC_WD-1:0] OFF_CMP1 = DEC_WD'('h2);
    localparam logic [DEC_WD-1:0] OFF_CMP2 = DEC_WD'('h4);
    localparam logic [DEC_WD-1:0] OFF_CMP3 = DEC_WD'('h6);
    localparam logic [DEC_WD-1:0] OFF_PER0 = DEC_WD'('h8);
    localparam logic [DEC_WD-1:0] OFF_PER1 = DEC_WD'('hA);
    localparam logic [DEC_WD-1:0] OFF_CTL  = DEC_WD'('hC);
    localparam logic [DEC_WD-1:0] OFF_STAT = DEC_WD'('hE);

    state_t      state_q, state_d;
    logic [15:0] cmp0_q, cmp1_q, cmp2_q, cmp3_q;
    logic [15:0] per0_q, per1_q;
    logic [2:0]  ctl_q;
    logic        ifg_q, missed_q;
    logic [63:0] cmp_active_q;

    logic              sel, wr, rd;
    logic [DEC_WD-1:0] offset;
    logic              ctl_wr_lo, stat_wr_lo;
    logic              arm, disarm, ifg_clr, missed_clr;
    logic [31:0]       period;
    logic [63:0]       cmp_staged;
    logic              hit, reload;
    logic [15:0]       rdata;

    function automatic logic [15:0] byte_wr(input logic [15:0] old_val,
                                            input logic [15:0] din,
                                            input logic [1:0]  we);
        byte_wr = {we[1] ? din[15:8] : old_val[15:8],
                   we[0] ? din[7:0]  : old_val[7:0]};
    endfunction

    assign sel        = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign offset     = {bus.per_addr[DEC_WD-2:0], 1'b0};
    assign wr         = sel & (|bus.per_we);
    assign rd         = sel & ~(|bus.per_we);

    assign ctl_wr_lo  = wr & (offset == OFF_CTL)  & bus.per_we[0];
    assign stat_wr_lo = wr & (offset == OFF_STAT) & bus.per_we[0];
    assign arm        = ctl_wr_lo &  bus.per_din[0];
    assign disarm     = ctl_wr_lo & ~bus.per_din[0];
    assign ifg_clr    = stat_wr_lo & bus.per_din[0];
    assign missed_clr = stat_wr_lo & bus.per_din[2];

    assign period     = {per1_q, per0_q};
    assign cmp_staged = {cmp3_q, cmp2_q, cmp1_q, cmp0_q};
    assign hit        = (state_q == ARMED) & (tsc >= cmp_active_q);
    // A periodic alarm with a zero period would fire every cycle, so it behaves as one-shot.
    assign reload     = hit & ctl_q[1] & (period != 32'd0);

    always_ff @(posedge mclk) begin
        if (puc_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm)
            state_d = ARMED;
        else if (disarm)
            state_d = IDLE;
        else if (hit && !reload)
            state_d = IDLE;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cmp0_q       <= 16'h0;
            cmp1_q       <= 16'h0;
            cmp2_q       <= 16'h0;
            cmp3_q       <= 16'h0;
            per0_q       <= 16'h0;
            per1_q       <= 16'h0;
            ctl_q        <= 3'b000;
            ifg_q        <= 1'b0;
            missed_q     <= 1'b0;
            cmp_active_q <= 64'h0;
        end else begin
            if (wr && offset == OFF_CMP0) cmp0_q <= byte_wr(cmp0_q, bus.per_din, bus.per_we);
            if (wr && offset == OFF_CMP1) cmp1_q <= byte_wr(cmp1_q, bus.per_din, bus.per_we);
            if (wr && offset == OFF_CMP2) cmp2_q <= byte_wr(cmp2_q, bus.per_din, bus.per_we);
            if (wr && offset == OFF_CMP3) cmp3_q <= byte_wr(cmp3_q, bus.per_din, bus.per_we);
            if (wr && offset == OFF_PER0) per0_q <= byte_wr(per0_q, bus.per_din, bus.per_we);
            if (wr && offset == OFF_PER1) per1_q <= byte_wr(per1_q, bus.per_din, bus.per_we);

            if (ctl_wr_lo)
                ctl_q <= bus.per_din[2:0];
            // One-shot completion drops EN unless a re-arm lands on the same edge.
            if (hit && !reload && !arm)
                ctl_q[0] <= 1'b0;

            if (arm)
                cmp_active_q <= cmp_staged;
            else if (reload)
                cmp_active_q <= cmp_active_q + {32'h0, period};

            if (hit)
                ifg_q <= 1'b1;
            else if (ifg_clr)
                ifg_q <= 1'b0;

            if (hit && ifg_q && !ifg_clr)
                missed_q <= 1'b1;
            else if (missed_clr)
                missed_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = 16'h0;
        if (rd) begin
            case (offset)
                OFF_CMP0: rdata = cmp0_q;
                OFF_CMP1: rdata = cmp1_q;
                OFF_CMP2: rdata = cmp2_q;
                OFF_CMP3: rdata = cmp3_q;
                OFF_PER0: rdata = per0_q;
                OFF_PER1: rdata = per1_q;
                OFF_CTL:  rdata = {13'h0, ctl_q};
                OFF_STAT: rdata = {13'h0, missed_q, state_q == ARMED, ifg_q};
                default:  rdata = 16'h0;
            endcase
        end
    end

    assign bus.per_dout = rdata;
    assign irq          = ifg_q & ctl_q[2];
endmodule

// File: tb/tb_omsp_tsc_alarm.sv
// tb/tb_omsp_tsc_alarm.sv - scoreboard bench for omsp_tsc_alarm
module tb_omsp_tsc_alarm;
    localparam logic [13:0] A_CMP0 = 14'h0088;
    localparam logic [13:0] A_CMP1 = 14'h0089;
    localparam logic [13:0] A_CMP2 = 14'h008A;
    localparam logic [13:0] A_CMP3 = 14'h008B;
    localparam logic [13:0] A_PER0 = 14'h008C;
    localparam logic [13:0] A_PER1 = 14'h008D;
    localparam logic [13:0] A_CTL  = 14'h008E;
    localparam logic [13:0] A_STAT = 14'h008F;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [63:0] tsc;
    logic        irq;
    logic        irq_probe;

    omsp_tsc_alarm_if bus ();

    omsp_tsc_alarm dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus.slave),
        .tsc     (tsc),
        .irq     (irq)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        bit          is_irq;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge mclk) begin
        exp_t e;
        if (bus.per_en && bus.per_we == 2'b00) begin
            n_tests++;
            if (sb.size() == 0 || sb[0].is_irq) begin
                n_fail++;
                $display("FAIL sb_unexpected_read: got %h, required a queued read expectation", bus.per_dout);
            end else begin
                e = sb.pop_front();
                if (bus.per_dout !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: per_dout=%h required=%h", e.name, bus.per_dout, e.exp);
                end
            end
        end
        if (irq_probe) begin
            n_tests++;
            if (sb.size() == 0 || !sb[0].is_irq) begin
                n_fail++;
                $display("FAIL sb_unexpected_irq: got %b, required a queued irq expectation", irq);
            end else begin
                e = sb.pop_front();
                if (irq !== e.exp[0]) begin
                    n_fail++;
                    $display("FAIL %s: irq=%b required=%b", e.name, irq, e.exp[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        bus.per_addr = a;
        bus.per_din  = d;
        bus.per_we   = we;
        bus.per_en   = 1'b1;
        tick();
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] e, input string n);
        exp_t x;
        x.is_irq = 1'b0;
        x.exp    = e;
        x.name   = n;
        sb.push_back(x);
        bus.per_addr = a;
        bus.per_we   = 2'b00;
        bus.per_en   = 1'b1;
        tick();
        bus.per_en   = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string n);
        exp_t x;
        x.is_irq = 1'b1;
        x.exp    = {15'h0, e};
        x.name   = n;
        sb.push_back(x);
        irq_probe = 1'b1;
        tick();
        irq_probe = 1'b0;
    endtask

    task automatic set_cmp(input logic [63:0] v);
        wr(A_CMP0, v[15:0],  2'b11);
        wr(A_CMP1, v[31:16], 2'b11);
        wr(A_CMP2, v[47:32], 2'b11);
        wr(A_CMP3, v[63:48], 2'b11);
    endtask

    initial begin
        puc_rst      = 1'b1;
        tsc          = 64'hF0;
        irq_probe    = 1'b0;
        bus.per_addr = 14'h0;
        bus.per_din  = 16'h0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        tick();
        tick();
        puc_rst = 1'b0;

        rd(A_CTL,  16'h0000, "rst_ctl");
        rd(A_STAT, 16'h0000, "rst_stat");
        rd(A_CMP0, 16'h0000, "rst_cmp0");
        chk_irq(1'b0, "rst_irq");

        // one-shot
        set_cmp(64'h100);
        wr(A_CTL, 16'h0005, 2'b11);
        tsc = 64'hFF;  chk_irq(1'b0, "os_pre");
        tsc = 64'h100; chk_irq(1'b0, "os_latency");
        chk_irq(1'b1, "os_irq");
        rd(A_STAT, 16'h0001, "os_stat");
        rd(A_CTL,  16'h0004, "os_ctl");
        wr(A_STAT, 16'h0001, 2'b01);
        rd(A_STAT, 16'h0000, "os_w1c");

        // periodic
        tsc = 64'h50;
        wr(A_PER0, 16'h0020, 2'b11);
        wr(A_PER1, 16'h0000, 2'b11);
        wr(A_CTL,  16'h0007, 2'b11);
        tsc = 64'h100; tick();
        rd(A_STAT, 16'h0003, "per_hit0");
        chk_irq(1'b1, "per_irq");
        wr(A_STAT, 16'h0001, 2'b01);
        tsc = 64'h120; tick();
        rd(A_STAT, 16'h0003, "per_hit1");
        wr(A_STAT, 16'h0001, 2'b01);
        tsc = 64'h140; tick();
        rd(A_STAT, 16'h0003, "per_hit2");
        wr(A_STAT, 16'h0001, 2'b01);
        rd(A_STAT, 16'h0002, "per_armed");
        wr(A_CTL, 16'h0000, 2'b11);
        rd(A_STAT, 16'h0000, "per_off");

        // missed
        tsc = 64'h50;
        wr(A_CTL, 16'h0007, 2'b11);
        tsc = 64'h100; tick();
        tsc = 64'h120; tick();
        rd(A_STAT, 16'h0007, "miss_stat");
        wr(A_STAT, 16'h0005, 2'b01);
        rd(A_STAT, 16'h0002, "miss_w1c");
        wr(A_CTL, 16'h0000, 2'b11);

        // wrap of cmp_active past 2^64
        tsc = 64'hFFFF_FFFF_FFFF_FFE0;
        set_cmp(64'hFFFF_FFFF_FFFF_FFF0);
        wr(A_CTL, 16'h0007, 2'b11);
        tsc = 64'hFFFF_FFFF_FFFF_FFF0; tick();
        tsc = 64'h5;
        wr(A_STAT, 16'h0001, 2'b01);
        rd(A_STAT, 16'h0002, "wrap_nohit5");
        tsc = 64'hF;
        rd(A_STAT, 16'h0002, "wrap_nohitF");
        tsc = 64'h10; tick();
        rd(A_STAT, 16'h0003, "wrap_hit");
        wr(A_CTL, 16'h0000, 2'b11);
        wr(A_STAT, 16'h0005, 2'b01);

        // W1C colliding with a hit
        tsc = 64'h50;
        set_cmp(64'h100);
        wr(A_CTL, 16'h0007, 2'b11);
        tsc = 64'h100; tick();
        tsc = 64'h120;
        wr(A_STAT, 16'h0001, 2'b01);
        rd(A_STAT, 16'h0003, "coll_stat");
        wr(A_CTL, 16'h0000, 2'b11);
        wr(A_STAT, 16'h0005, 2'b01);

        // byte-lane write
        wr(A_CMP1, 16'h1234, 2'b11);
        wr(A_CMP1, 16'hABCD, 2'b01);
        rd(A_CMP1, 16'h12CD, "byte_cmp1");
        wr(A_CMP1, 16'h0000, 2'b11);

        // arming write colliding with a hit
        tsc = 64'h50;
        wr(A_CMP0, 16'h0100, 2'b11);
        wr(A_CTL,  16'h0007, 2'b11);
        wr(A_CMP0, 16'h0300, 2'b11);
        tsc = 64'h100;
        wr(A_CTL, 16'h0007, 2'b11);
        rd(A_STAT, 16'h0003, "armhit_ifg");
        tsc = 64'h120;
        wr(A_STAT, 16'h0001, 2'b01);
        rd(A_STAT, 16'h0002, "armhit_reload");
        tsc = 64'h300; tick();
        rd(A_STAT, 16'h0003, "armhit_new");
        wr(A_CTL, 16'h0000, 2'b11);
        wr(A_STAT, 16'h0001, 2'b01);

        // reset coinciding with a hit
        tsc = 64'h50;
        wr(A_CMP0, 16'h0100, 2'b11);
        wr(A_CTL,  16'h0005, 2'b11);
        rd(14'h0080, 16'h0000, "unsel_rd");
        tsc = 64'h100;
        puc_rst = 1'b1;
        tick();
        puc_rst = 1'b0;
        rd(A_CMP0, 16'h0000, "prst_cmp0");
        rd(A_PER0, 16'h0000, "prst_per0");
        rd(A_CTL,  16'h0000, "prst_ctl");
        rd(A_STAT, 16'h0000, "prst_stat");
        chk_irq(1'b0, "prst_irq");

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
